seq_generator: RTL and testbench
================================

// Module: seq_generator
// PURPOSE
//  Serial bit-pattern generator: transmit side of the serial sequence stream consumed by seq_detector.
//  Latches a PAT_W-bit pattern and repeat count on start, then shifts the pattern out MSB-first, one bit per clk.
//  Optional idle gap between repetitions. Drives detector stimulus in benches and on-chip self-test.
// PARAMETERS
//  PAT_W   4  pattern width in bits (>=2)
//  CNT_W   4  width of repeat-count input
//  GAP     0  idle cycles inserted between consecutive repetitions (0 = back-to-back)
// PORTS
//  clk      in   1      single clock, rising edge
//  reset    in   1      asynchronous, active-high reset
//  start    in   1      request a transmission; sampled only when busy=0
//  pattern  in   PAT_W  pattern to send, MSB first; latched when start accepted
//  repeat   in   CNT_W  number of pattern repetitions; latched when start accepted
//  stop     in   1      synchronous abort
//  x        out  1      serial data bit (0 when x_valid=0)
//  x_valid  out  1      x carries a pattern bit this cycle
//  busy     out  1      transmission in progress
//  done     out  1      one-cycle pulse after last bit of last repetition
// BEHAVIOUR
//  - Reset: x=0, x_valid=0, busy=0, done=0, state=IDLE, all counters/shift reg cleared; asserting reset mid-frame clears outputs immediately.
//  - All outputs registered. States: IDLE, SEND, GAP.
//  - IDLE: start=1 & stop=0 at edge N -> latch pattern/repeat; from edge N: state=SEND, x=pattern[PAT_W-1], x_valid=1, busy=1.
//  - SEND: each edge shifts left; bit index counts 0..PAT_W-1. After bit PAT_W-1:
//    - reps remaining >1 & GAP>0 -> GAP for exactly GAP cycles (x=0, x_valid=0, busy=1), then SEND from MSB.
//    - reps remaining >1 & GAP=0 -> next bit is pattern MSB again, no bubble.
//    - last repetition -> IDLE; busy=0 and done=1 for exactly one cycle.
//  - repeat=0 treated as 1 (see CONFIGURATION).
//  - Latency: first bit on x in cycle after the edge that samples start; frame of R reps = R*PAT_W + (R-1)*GAP cycles of busy.
//  - start while busy=1: ignored; pattern/repeat inputs not re-latched.
//  - start during done cycle (busy=0): accepted; next frame back-to-back, done pulses once per frame.
//  - stop=1 in any state: next edge -> IDLE, x=0, x_valid=0, busy=0, done NOT pulsed. stop and start same cycle: stop wins.
//  - Repeat counter decrements at end of each repetition; never wraps below 1.
// CONFIGURATION
//  SEQ_GEN_LOOP_EN defined: repeat=0 means continuous repetition until stop; done never pulses in loop mode.
//  SEQ_GEN_LOOP_EN undefined: repeat=0 behaves as repeat=1 (single frame, done pulses).
// TESTING (PAT_W=4, CNT_W=4)
//  1. reset 15 ns, start, pattern=4'b0110, repeat=1, GAP=0 -> x=0,1,1,0 with x_valid=1 4 cycles; busy 4 cycles; done=1 cycle 5.
//  2. pattern=4'b0110, repeat=3, GAP=0 -> 12 contiguous valid bits 011001100110, single done pulse after bit 12.
//  3. GAP=2, pattern=4'b1011, repeat=2 -> 1011, 2 cycles x_valid=0/x=0, 1011, done; busy high 10 cycles.
//  4. start pulsed mid-frame with pattern=4'b1111 -> ignored, frame bits unchanged; start in done cycle with 4'b1001 -> 1001 begins next cycle.
//  5. stop during 2nd bit -> next cycle x_valid=0, busy=0, no done; reset asserted mid-frame -> all outputs 0 before next clk edge.
//  6. repeat=0: with SEQ_GEN_LOOP_EN -> pattern repeats 5+ times until stop, no done; without -> one frame, done pulses.

Source files
------------

// File: rtl/seq_generator.sv
// Serial bit-pattern generator: latches a pattern and repeat count on start, then
// shifts it out MSB-first with an optional idle gap between repetitions. Optional macro: SEQ_GEN_LOOP_EN.
module seq_generator #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             stop,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             loop_q, loop_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             rep_zero_c;
    logic             loop_start_c;

    assign rep_zero_c = (repeat_cnt == '0);

    // A zero repeat count selects endless repetition only when looping is built in.
`ifdef SEQ_GEN_LOOP_EN
    assign loop_start_c = rep_zero_c;
`else
    assign loop_start_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            reps_q    <= '0;
            gap_q     <= '0;
            loop_q    <= 1'b0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            reps_q    <= reps_d;
            gap_q     <= gap_d;
            loop_q    <= loop_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; the x/x_valid/busy/done values describe the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        reps_d    = reps_q;
        gap_d     = gap_q;
        loop_d    = loop_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            loop_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_SEND;
                        pat_d     = pattern;
                        shift_d   = pattern;
                        idx_d     = '0;
                        reps_d    = rep_zero_c ? CNT_W'(1) : repeat_cnt;
                        loop_d    = loop_start_c;
                        x_d       = pattern[PAT_W-1];
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
                ST_SEND: begin
                    if (idx_q != IDX_W'(PAT_W - 1)) begin
                        shift_d   = {shift_q[PAT_W-2:0], 1'b0};
                        idx_d     = idx_q + 1'b1;
                        x_d       = shift_q[PAT_W-2];
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end else if (!loop_q && reps_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        if (!loop_q) begin
                            reps_d = reps_q - 1'b1;
                        end
                        busy_d = 1'b1;
                        if (GAP > 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else begin
                            shift_d   = pat_q;
                            idx_d     = '0;
                            x_d       = pat_q[PAT_W-1];
                            x_valid_d = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    busy_d = 1'b1;
                    if (gap_q == GAP_W'(GAP - 1)) begin
                        state_d   = ST_SEND;
                        shift_d   = pat_q;
                        idx_d     = '0;
                        x_d       = pat_q[PAT_W-1];
                        x_valid_d = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: two instances (GAP=0 and GAP=2) checked every cycle
// against a frame-queue model, plus literal expectations for directed frames.
module tb_seq_generator;

    typedef struct packed {
        logic x;
        logic v;
        logic b;
        logic d;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start_s [2];
    logic [3:0] pat_s   [2];
    logic [3:0] rep_s   [2];
    logic       stop_s  [2];
    logic       x_s     [2];
    logic       xv_s    [2];
    logic       busy_s  [2];
    logic       done_s  [2];

    int checks;
    int errors;

    exp_t q   [2][$];
    exp_t cur [2];

    seq_generator #(.PAT_W(4), .CNT_W(4), .GAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .pattern(pat_s[0]),
        .repeat_cnt(rep_s[0]), .stop(stop_s[0]), .x(x_s[0]), .x_valid(xv_s[0]),
        .busy(busy_s[0]), .done(done_s[0])
    );

    seq_generator #(.PAT_W(4), .CNT_W(4), .GAP(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .pattern(pat_s[1]),
        .repeat_cnt(rep_s[1]), .stop(stop_s[1]), .x(x_s[1]), .x_valid(xv_s[1]),
        .busy(busy_s[1]), .done(done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    // Expand an accepted request into the full sequence of future output cycles.
    function automatic void build(int i, logic [3:0] p, logic [3:0] r);
        int   reps;
        int   gap;
        logic endless;
        reps    = (r == 4'd0) ? 1 : int'(r);
        endless = 1'b0;
`ifdef SEQ_GEN_LOOP_EN
        if (r == 4'd0) begin
            reps    = 60;
            endless = 1'b1;
        end
`endif
        gap = (i == 0) ? 0 : 2;
        q[i].delete();
        for (int k = 0; k < reps; k++) begin
            for (int b = 3; b >= 0; b--) q[i].push_back('{x: p[b], v: 1'b1, b: 1'b1, d: 1'b0});
            if (k < reps - 1)
                for (int g = 0; g < gap; g++) q[i].push_back('{x: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0});
        end
        if (!endless) q[i].push_back('{x: 1'b0, v: 1'b0, b: 1'b0, d: 1'b1});
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || stop_s[i]) begin
                q[i].delete();
                cur[i] = '0;
            end else begin
                if (start_s[i] && !cur[i].b) build(i, pat_s[i], rep_s[i]);
                cur[i] = (q[i].size() > 0) ? q[i].pop_front() : exp_t'(0);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("i%0d.x", i),       64'(x_s[i]),    64'(cur[i].x));
                chk($sformatf("i%0d.x_valid", i), 64'(xv_s[i]),   64'(cur[i].v));
                chk($sformatf("i%0d.busy", i),    64'(busy_s[i]), 64'(cur[i].b));
                chk($sformatf("i%0d.done", i),    64'(done_s[i]), 64'(cur[i].d));
            end
        end
    end

    // Call at a negedge; returns at the negedge of the first cycle with busy low.
    task automatic run_frame(input int inst, input logic [3:0] pat, input logic [3:0] rep,
                             input int inj_c, input logic [3:0] inj_p, input int stop_c,
                             output logic [63:0] bits, output int nb, output int busy_n,
                             output int done_n, output int first_v, output int done_at);
        logic finished;
        bits = '0; nb = 0; busy_n = 0; done_n = 0; first_v = 0; done_at = 0;
        finished = 1'b0;
        start_s[inst] = 1'b1;
        pat_s[inst]   = pat;
        rep_s[inst]   = rep;
        for (int c = 1; c <= 200 && !finished; c++) begin
            @(negedge clk);
            if (xv_s[inst]) begin
                bits = {bits[62:0], x_s[inst]};
                nb++;
                if (first_v == 0) first_v = c;
            end
            if (busy_s[inst]) busy_n++;
            if (done_s[inst]) begin
                done_n++;
                done_at = c;
            end
            start_s[inst] = (c == inj_c);
            if (c == inj_c) pat_s[inst] = inj_p;
            stop_s[inst] = (c == stop_c);
            if (!busy_s[inst]) finished = 1'b1;
        end
        start_s[inst] = 1'b0;
        stop_s[inst]  = 1'b0;
        chk("frame_end", 64'(finished), 64'd1);
    endtask

    logic [63:0] bits;
    int nb, bn, dn, fv, da;

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; pat_s[i] = '0; rep_s[i] = '0; stop_s[i] = 1'b0;
        end
        reset = 1'b1;
        #12;
        chk("rst.x",       64'(x_s[0]),    64'd0);
        chk("rst.x_valid", 64'(xv_s[0]),   64'd0);
        chk("rst.busy",    64'(busy_s[0]), 64'd0);
        chk("rst.done",    64'(done_s[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_frame(0, 4'b0110, 4'd1, 0, 4'h0, 0, bits, nb, bn, dn, fv, da);
        chk("t1.bits", bits, 64'b0110);
        chk("t1.nb", 64'(nb), 64'd4);
        chk("t1.busy", 64'(bn), 64'd4);
        chk("t1.first", 64'(fv), 64'd1);
        chk("t1.done_at", 64'(da), 64'd5);

        run_frame(0, 4'b0110, 4'd3, 0, 4'h0, 0, bits, nb, bn, dn, fv, da);
        chk("t2.bits", bits, 64'b011001100110);
        chk("t2.nb", 64'(nb), 64'd12);
        chk("t2.done_n", 64'(dn), 64'd1);
        chk("t2.done_at", 64'(da), 64'd13);

        run_frame(1, 4'b1011, 4'd2, 0, 4'h0, 0, bits, nb, bn, dn, fv, da);
        chk("t3.bits", bits, 64'b10111011);
        chk("t3.busy", 64'(bn), 64'd10);
        chk("t3.done_at", 64'(da), 64'd11);

        run_frame(0, 4'b0110, 4'd2, 3, 4'b1111, 0, bits, nb, bn, dn, fv, da);
        chk("t4.bits", bits, 64'b01100110);
        chk("t4.done_n", 64'(dn), 64'd1);
        run_frame(0, 4'b1001, 4'd1, 0, 4'h0, 0, bits, nb, bn, dn, fv, da);
        chk("t4b.bits", bits, 64'b1001);
        chk("t4b.first", 64'(fv), 64'd1);

        run_frame(0, 4'b0110, 4'd2, 0, 4'h0, 2, bits, nb, bn, dn, fv, da);
        chk("t5.bits", bits, 64'b01);
        chk("t5.busy", 64'(bn), 64'd2);
        chk("t5.done_n", 64'(dn), 64'd0);

        start_s[0] = 1'b1; stop_s[0] = 1'b1; pat_s[0] = 4'b1111; rep_s[0] = 4'd1;
        @(negedge clk);
        start_s[0] = 1'b0; stop_s[0] = 1'b0;
        chk("t5.stopwins", 64'(busy_s[0]), 64'd0);

        start_s[0] = 1'b1; pat_s[0] = 4'b0110; rep_s[0] = 4'd3;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5.rst_x",    64'(x_s[0]),    64'd0);
        chk("t5.rst_xv",   64'(xv_s[0]),   64'd0);
        chk("t5.rst_busy", 64'(busy_s[0]), 64'd0);
        chk("t5.rst_done", 64'(done_s[0]), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

`ifdef SEQ_GEN_LOOP_EN
        run_frame(0, 4'b0110, 4'd0, 0, 4'h0, 22, bits, nb, bn, dn, fv, da);
        chk("t6.many", 64'(nb >= 20), 64'd1);
        chk("t6.done_n", 64'(dn), 64'd0);
`else
        run_frame(0, 4'b0110, 4'd0, 0, 4'h0, 0, bits, nb, bn, dn, fv, da);
        chk("t6.bits", bits, 64'b0110);
        chk("t6.done_n", 64'(dn), 64'd1);
`endif
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
